forward_module: RTL and testbench

- Forward-inference engine for the 9-state / 5-hidden / 4-action Q-network.
- Given state index st, it computes hidden activations a2 (sigmoid) and Q-values a3 (linear output) using serial multiply-accumulate over an external weight store.
- It publishes a2, a3, the greedy action and maxQ, which feed the backward/update path and the action selector.

---
 rtl/forward_module_pkg.sv | 44 ++++
 rtl/forward_module_sigmoid_pwl.sv | 32 +++
 rtl/forward_module.sv | 264 ++++++++++++++++++++++++++
 tb/tb_forward_module.sv | 383 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/forward_module_pkg.sv
// Shared constants, FSM encoding and helpers for the Q-network forward pass.
// Q4.12 fixed point throughout; weight-store map bases live here.
package forward_module_pkg;

    localparam int FRAC_BITS = 12;
    localparam int N_IN      = 9;
    localparam int N_HID     = 5;
    localparam int N_OUT     = 4;

    localparam logic signed [15:0] ONE_Q   = 16'sd4096;
    localparam logic signed [15:0] SAT_MAX = 16'sh7FFF;
    localparam logic signed [15:0] SAT_MIN = 16'sh8000;

    localparam logic [6:0] W2_BASE = 7'd0;
    localparam logic [6:0] B2_BASE = 7'd45;
    localparam logic [6:0] W3_BASE = 7'd50;
    localparam logic [6:0] B3_BASE = 7'd70;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_ARGMAX,
        S_DONE
    } state_t;

    // Position of a read within the sequence: layer, neuron, step.
    typedef struct packed {
        logic       l3;
        logic [2:0] n;
        logic [2:0] s;
    } tag_t;

    function automatic logic signed [15:0] sat16(
        input logic signed [31:0] v
    );
        if (v > 32'sd32767)
            return SAT_MAX;
        else if (v < -32'sd32768)
            return SAT_MIN;
        else
            return v[15:0];
    endfunction

endpackage

// File: rtl/forward_module_sigmoid_pwl.sv
// PLAN piecewise-linear sigmoid on Q4.12, shifts and adds only.
// Built on |x|; negative inputs mirror as 1.0 - y.
module sigmoid_pwl
    import forward_module_pkg::*;
(
    input  logic signed [15:0] x,
    output logic signed [15:0] y
);

    logic [15:0] ax;
    logic [15:0] yp;

    // Magnitude, segment select, then mirror for negative inputs.
    always_comb begin
        ax = x[15] ? 16'(-x) : 16'(x);
        if (ax >= 16'd20480)
            yp = 16'(ONE_Q);
        else if (ax >= 16'd9728)
            yp = (ax >> 5) + 16'd3456;
        else if (ax >= 16'd4096)
            yp = (ax >> 3) + 16'd2560;
        else
            yp = (ax >> 2) + 16'd2048;
        if (x == SAT_MIN)
            y = 16'sd0;
        else if (x[15])
            y = ONE_Q - $signed(yp);
        else
            y = $signed(yp);
    end

endmodule

// File: rtl/forward_module.sv
// Forward pass of the 9/5/4 Q-network: serial MAC over an external
// weight store, sigmoid hidden layer, linear output, greedy argmax.
module forward_module
    import forward_module_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [3:0]         st,
    output logic               busy,
    output logic               done,
    output logic               st_err,
    output logic               w_rd,
    output logic [6:0]         w_addr,
    input  logic signed [15:0] w_data,
    output logic signed [15:0] a2_0,
    output logic signed [15:0] a2_1,
    output logic signed [15:0] a2_2,
    output logic signed [15:0] a2_3,
    output logic signed [15:0] a2_4,
    output logic signed [15:0] a3_0,
    output logic signed [15:0] a3_1,
    output logic signed [15:0] a3_2,
    output logic signed [15:0] a3_3,
    output logic [1:0]         act,
    output logic signed [15:0] maxq
);

    state_t state_q, state_d;
    logic [3:0] st_q, st_d;
    logic err_q, err_d;
    logic w_rd_q, w_rd_d;
    logic [6:0] w_addr_q, w_addr_d;
    tag_t iss_q, iss_d;
    logic iss_end_q, iss_end_d;
    tag_t rtag_q, rtag_d;
    logic dv_q, dv_d;
    tag_t dtag_q, dtag_d;
    logic signed [15:0] w2_q, w2_d;
    logic signed [31:0] acc_q, acc_d;
    logic signed [15:0] a2w_q [N_HID];
    logic signed [15:0] a2w_d [N_HID];
    logic signed [15:0] a3w_q [N_OUT];
    logic signed [15:0] a3w_d [N_OUT];
    logic signed [15:0] a2o_q [N_HID];
    logic signed [15:0] a2o_d [N_HID];
    logic signed [15:0] a3o_q [N_OUT];
    logic signed [15:0] a3o_d [N_OUT];
    logic [1:0] act_q, act_d;
    logic signed [15:0] maxq_q, maxq_d;

    logic signed [15:0] z2;
    logic signed [15:0] sig_y;
    logic signed [15:0] a2_sel;
    logic signed [31:0] acc_nx;
    logic [1:0] best_i;
    logic signed [15:0] best_v;
    logic [3:0] st_eff;
    logic [6:0] n7;
    logic [6:0] s7;

    sigmoid_pwl u_sig (
        .x (z2),
        .y (sig_y)
    );

    // Hidden pre-activation and output-layer MAC step on returning data.
    always_comb begin
        z2 = sat16(32'(w2_q) + 32'(w_data));
        unique case (dtag_q.s)
            3'd1:    a2_sel = a2w_q[0];
            3'd2:    a2_sel = a2w_q[1];
            3'd3:    a2_sel = a2w_q[2];
            3'd4:    a2_sel = a2w_q[3];
            3'd5:    a2_sel = a2w_q[4];
            default: a2_sel = 16'sd0;
        endcase
        acc_nx = acc_q + 32'(w_data) * 32'(a2_sel);
    end

    // Greedy action: strictly greater wins, ties keep the lower index.
    always_comb begin
        best_i = 2'd0;
        best_v = a3w_q[0];
        for (int k = 1; k < N_OUT; k++) begin
            if (a3w_q[k] > best_v) begin
                best_i = 2'(k);
                best_v = a3w_q[k];
            end
        end
    end

    // FSM, read issue sequencer, data consumption and output load.
    always_comb begin
        state_d   = state_q;
        st_d      = st_q;
        err_d     = err_q;
        w_rd_d    = 1'b0;
        w_addr_d  = 7'd0;
        iss_d     = iss_q;
        iss_end_d = iss_end_q;
        rtag_d    = iss_q;
        dv_d      = w_rd_q;
        dtag_d    = rtag_q;
        w2_d      = w2_q;
        acc_d     = acc_q;
        a2w_d     = a2w_q;
        a3w_d     = a3w_q;
        a2o_d     = a2o_q;
        a3o_d     = a3o_q;
        act_d     = act_q;
        maxq_d    = maxq_q;
        st_eff    = err_q ? 4'd0 : st_q;
        n7        = {4'd0, iss_q.n};
        s7        = {4'd0, iss_q.s};

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d   = S_RUN;
                    st_d      = st;
                    err_d     = (st > 4'(N_IN - 1));
                    iss_d     = '0;
                    iss_end_d = 1'b0;
                end
            end
            S_RUN: begin
                if (!iss_end_q) begin
                    w_rd_d = 1'b1;
                    if (!iss_q.l3) begin
                        if (iss_q.s == 3'd0)
                            w_addr_d = W2_BASE + n7 * 7'd9
                                     + {3'd0, st_eff};
                        else
                            w_addr_d = B2_BASE + n7;
                        if (iss_q.s == 3'd1) begin
                            iss_d.s = 3'd0;
                            if (iss_q.n == 3'(N_HID - 1)) begin
                                iss_d.l3 = 1'b1;
                                iss_d.n  = 3'd0;
                            end else begin
                                iss_d.n = iss_q.n + 3'd1;
                            end
                        end else begin
                            iss_d.s = 3'd1;
                        end
                    end else begin
                        if (iss_q.s == 3'd0)
                            w_addr_d = B3_BASE + n7;
                        else
                            w_addr_d = W3_BASE + n7 * 7'd5
                                     + s7 - 7'd1;
                        if (iss_q.s == 3'd5) begin
                            iss_d.s = 3'd0;
                            if (iss_q.n == 3'(N_OUT - 1))
                                iss_end_d = 1'b1;
                            else
                                iss_d.n = iss_q.n + 3'd1;
                        end else begin
                            iss_d.s = iss_q.s + 3'd1;
                        end
                    end
                end
                if (dv_q) begin
                    if (!dtag_q.l3) begin
                        if (dtag_q.s == 3'd0) begin
                            w2_d = err_q ? 16'sd0 : w_data;
                        end else begin
                            for (int i = 0; i < N_HID; i++)
                                if (dtag_q.n == 3'(i))
                                    a2w_d[i] = sig_y;
                        end
                    end else if (dtag_q.s == 3'd0) begin
                        acc_d = 32'(w_data) <<< FRAC_BITS;
                    end else begin
                        acc_d = acc_nx;
                        if (dtag_q.s == 3'd5) begin
                            for (int k = 0; k < N_OUT; k++)
                                if (dtag_q.n == 3'(k))
                                    a3w_d[k] = sat16(
                                        acc_nx >>> FRAC_BITS);
                            if (dtag_q.n == 3'(N_OUT - 1))
                                state_d = S_ARGMAX;
                        end
                    end
                end
            end
            S_ARGMAX: begin
                state_d = S_DONE;
                a2o_d   = a2w_q;
                a3o_d   = a3w_q;
                act_d   = best_i;
                maxq_d  = best_v;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset aborts any run in progress.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            st_q      <= 4'd0;
            err_q     <= 1'b0;
            w_rd_q    <= 1'b0;
            w_addr_q  <= 7'd0;
            iss_q     <= '0;
            iss_end_q <= 1'b0;
            rtag_q    <= '0;
            dv_q      <= 1'b0;
            dtag_q    <= '0;
            w2_q      <= 16'sd0;
            acc_q     <= 32'sd0;
            a2w_q     <= '{default: 16'sd0};
            a3w_q     <= '{default: 16'sd0};
            a2o_q     <= '{default: 16'sd0};
            a3o_q     <= '{default: 16'sd0};
            act_q     <= 2'd0;
            maxq_q    <= 16'sd0;
        end else begin
            state_q   <= state_d;
            st_q      <= st_d;
            err_q     <= err_d;
            w_rd_q    <= w_rd_d;
            w_addr_q  <= w_addr_d;
            iss_q     <= iss_d;
            iss_end_q <= iss_end_d;
            rtag_q    <= rtag_d;
            dv_q      <= dv_d;
            dtag_q    <= dtag_d;
            w2_q      <= w2_d;
            acc_q     <= acc_d;
            a2w_q     <= a2w_d;
            a3w_q     <= a3w_d;
            a2o_q     <= a2o_d;
            a3o_q     <= a3o_d;
            act_q     <= act_d;
            maxq_q    <= maxq_d;
        end
    end

    assign busy   = (state_q == S_RUN) || (state_q == S_ARGMAX);
    assign done   = (state_q == S_DONE);
    assign st_err = err_q;
    assign w_rd   = w_rd_q;
    assign w_addr = w_addr_q;
    assign a2_0   = a2o_q[0];
    assign a2_1   = a2o_q[1];
    assign a2_2   = a2o_q[2];
    assign a2_3   = a2o_q[3];
    assign a2_4   = a2o_q[4];
    assign a3_0   = a3o_q[0];
    assign a3_1   = a3o_q[1];
    assign a3_2   = a3o_q[2];
    assign a3_3   = a3o_q[3];
    assign act    = act_q;
    assign maxq   = maxq_q;

endmodule

// File: tb/tb_forward_module.sv
// Bench for forward_module: weight-store responder, reference model,
// expected results queued at launch and compared when done fires.
module tb_forward_module;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               start = 1'b0;
    logic [3:0]         st = 4'd0;
    logic               busy, done, st_err, w_rd;
    logic [6:0]         w_addr;
    logic signed [15:0] w_data = 16'sd0;
    logic signed [15:0] a2_0, a2_1, a2_2, a2_3, a2_4;
    logic signed [15:0] a3_0, a3_1, a3_2, a3_3;
    logic [1:0]         act;
    logic signed [15:0] maxq;

    typedef struct packed {
        logic             err;
        logic [1:0]       act;
        logic [15:0]      maxq;
        logic [3:0][15:0] a3;
        logic [4:0][15:0] a2;
    } res_t;

    logic signed [15:0] wmem [0:79];
    res_t exp_q [$];
    int n_chk = 0;
    int n_pass = 0;

    forward_module dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .st     (st),
        .busy   (busy),
        .done   (done),
        .st_err (st_err),
        .w_rd   (w_rd),
        .w_addr (w_addr),
        .w_data (w_data),
        .a2_0   (a2_0),
        .a2_1   (a2_1),
        .a2_2   (a2_2),
        .a2_3   (a2_3),
        .a2_4   (a2_4),
        .a3_0   (a3_0),
        .a3_1   (a3_1),
        .a3_2   (a3_2),
        .a3_3   (a3_3),
        .act    (act),
        .maxq   (maxq)
    );

    always #5 clk = ~clk;

    // Weight store: one-cycle read latency.
    always @(posedge clk)
        w_data <= w_rd ? wmem[w_addr] : 16'sd0;

    function automatic int sig_ref(input int z);
        int ax, y;
        if (z == -32768) return 0;
        ax = (z < 0) ? -z : z;
        if (ax >= 20480)     y = 4096;
        else if (ax >= 9728) y = ax / 32 + 3456;
        else if (ax >= 4096) y = ax / 8 + 2560;
        else                 y = ax / 4 + 2048;
        return (z < 0) ? 4096 - y : y;
    endfunction

    function automatic int clamp(input int v);
        if (v > 32767)  return 32767;
        if (v < -32768) return -32768;
        return v;
    endfunction

    function automatic res_t model(input int s);
        res_t r;
        int h [5];
        int q [4];
        int z, acc, best;
        r = '0;
        r.err = (s > 8);
        for (int i = 0; i < 5; i++) begin
            z = (s > 8) ? 0 : int'(wmem[i * 9 + s]);
            z = clamp(z + int'(wmem[45 + i]));
            h[i] = sig_ref(z);
            r.a2[i] = 16'(h[i]);
        end
        for (int k = 0; k < 4; k++) begin
            acc = int'(wmem[70 + k]) * 4096;
            for (int i = 0; i < 5; i++)
                acc += int'(wmem[50 + k * 5 + i]) * h[i];
            q[k] = clamp(acc >>> 12);
            r.a3[k] = 16'(q[k]);
        end
        best = 0;
        for (int k = 1; k < 4; k++)
            if (q[k] > q[best]) best = k;
        r.act  = 2'(best);
        r.maxq = 16'(q[best]);
        return r;
    endfunction

    function automatic res_t dut_res();
        res_t r;
        r.err  = st_err;
        r.act  = act;
        r.maxq = maxq;
        r.a3   = {a3_3, a3_2, a3_1, a3_0};
        r.a2   = {a2_4, a2_3, a2_2, a2_1, a2_0};
        return r;
    endfunction

    task automatic clear_mem();
        for (int a = 0; a < 80; a++) wmem[a] = 16'sd0;
    endtask

    // Pulse start, measure cycles to done (bounded), step one more.
    task automatic launch(input logic [3:0] s, output int lat,
                          output logic d_next);
        @(negedge clk);
        st = s;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        lat = -1;
        for (int c = 1; c <= 100 && lat < 0; c++) begin
            @(posedge clk);
            #1;
            if (done === 1'b1) lat = c;
        end
        @(posedge clk);
        #1 d_next = done;
    endtask

    task automatic test_reset();
        res_t got;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        got = dut_res();
        n_chk++;
        if (got !== '0)
            $display("FAIL reset_outputs got=%h want=0", got);
        else n_pass++;
        n_chk++;
        if ({busy, done, w_rd, w_addr} !== 10'd0)
            $display("FAIL reset_ctrl got=%b want=0",
                     {busy, done, w_rd, w_addr});
        else n_pass++;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_zero();
        res_t got, exp;
        int lat;
        logic dn;
        clear_mem();
        exp_q.push_back(model(2));
        launch(4'd2, lat, dn);
        got = dut_res();
        exp = exp_q.pop_front();
        n_chk++;
        if (lat !== 37) $display("FAIL zero_latency got=%0d want=37", lat);
        else n_pass++;
        n_chk++;
        if (got !== exp)
            $display("FAIL zero_result got=%h want=%h", got, exp);
        else n_pass++;
        n_chk++;
        if (a2_3 !== 16'sd2048)
            $display("FAIL zero_a2 got=%0d want=2048", a2_3);
        else n_pass++;
        n_chk++;
        if (act !== 2'd0 || maxq !== 16'sd0)
            $display("FAIL zero_tie got=%0d/%0d want=0/0", act, maxq);
        else n_pass++;
        n_chk++;
        if (dn !== 1'b0)
            $display("FAIL done_pulse_width got=%b want=0", dn);
        else n_pass++;
    endtask

    task automatic test_b3_only();
        res_t got, exp;
        int lat;
        logic dn;
        clear_mem();
        wmem[72] = 16'sd4096;
        exp_q.push_back(model(0));
        launch(4'd0, lat, dn);
        got = dut_res();
        exp = exp_q.pop_front();
        n_chk++;
        if (got !== exp)
            $display("FAIL b3_result got=%h want=%h", got, exp);
        else n_pass++;
        n_chk++;
        if (act !== 2'd2 || maxq !== 16'sd4096)
            $display("FAIL b3_argmax got=%0d/%0d want=2/4096", act, maxq);
        else n_pass++;
    endtask

    task automatic test_w2_path();
        res_t got, exp;
        int lat;
        logic dn;
        clear_mem();
        wmem[3]  = 16'sd8192;
        wmem[55] = 16'sd4096;
        exp_q.push_back(model(3));
        launch(4'd3, lat, dn);
        got = dut_res();
        exp = exp_q.pop_front();
        n_chk++;
        if (got !== exp)
            $display("FAIL w2_result got=%h want=%h", got, exp);
        else n_pass++;
        n_chk++;
        if (a2_0 !== 16'sd3584 || a2_1 !== 16'sd2048)
            $display("FAIL w2_a2 got=%0d,%0d want=3584,2048", a2_0, a2_1);
        else n_pass++;
        n_chk++;
        if (a3_1 !== 16'sd3584 || act !== 2'd1 || maxq !== 16'sd3584)
            $display("FAIL w2_a3 got=%0d/%0d/%0d want=3584/1/3584",
                     a3_1, act, maxq);
        else n_pass++;
    endtask

    task automatic test_saturate();
        res_t got, exp;
        int lat;
        logic dn;
        clear_mem();
        for (int a = 45; a < 74; a++) wmem[a] = 16'sh7FFF;
        exp_q.push_back(model(5));
        launch(4'd5, lat, dn);
        got = dut_res();
        exp = exp_q.pop_front();
        n_chk++;
        if (got !== exp)
            $display("FAIL sat_result got=%h want=%h", got, exp);
        else n_pass++;
        n_chk++;
        if (a2_2 !== 16'sd4096 || a3_3 !== 16'sd32767 || act !== 2'd0)
            $display("FAIL sat_values got=%0d/%0d/%0d want=4096/32767/0",
                     a2_2, a3_3, act);
        else n_pass++;
    endtask

    task automatic test_st_err();
        res_t got, exp;
        int lat;
        logic dn;
        clear_mem();
        for (int a = 0; a < 45; a++) wmem[a] = 16'sd8192;
        exp_q.push_back(model(9));
        launch(4'd9, lat, dn);
        got = dut_res();
        exp = exp_q.pop_front();
        n_chk++;
        if (lat !== 37) $display("FAIL err_latency got=%0d want=37", lat);
        else n_pass++;
        n_chk++;
        if (got !== exp)
            $display("FAIL err_result got=%h want=%h", got, exp);
        else n_pass++;
        n_chk++;
        if (st_err !== 1'b1 || a2_4 !== 16'sd2048)
            $display("FAIL err_flag got=%b/%0d want=1/2048", st_err, a2_4);
        else n_pass++;
    endtask

    task automatic test_random();
        res_t got, exp;
        int lat, s;
        logic dn;
        for (int r = 0; r < 3; r++) begin
            for (int a = 0; a < 80; a++)
                wmem[a] = 16'($urandom);
            s = $urandom_range(0, 10);
            exp_q.push_back(model(s));
            launch(4'(s), lat, dn);
            got = dut_res();
            exp = exp_q.pop_front();
            n_chk++;
            if (lat !== 37)
                $display("FAIL rand_latency got=%0d want=37", lat);
            else n_pass++;
            n_chk++;
            if (got !== exp)
                $display("FAIL rand_result got=%h want=%h", got, exp);
            else n_pass++;
        end
    endtask

    task automatic test_back_to_back();
        res_t got, exp;
        int first, ndone;
        // Abort a run mid-way with reset.
        clear_mem();
        wmem[70] = 16'sd1000;
        @(negedge clk);
        st = 4'd1;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (19) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        got = dut_res();
        n_chk++;
        if (got !== '0 || busy !== 1'b0 || w_rd !== 1'b0)
            $display("FAIL abort_clear got=%h/%b/%b want=0", got, busy, w_rd);
        else n_pass++;
        @(negedge clk);
        rst = 1'b0;
        ndone = 0;
        for (int c = 0; c < 40; c++) begin
            @(posedge clk);
            #1;
            if (done === 1'b1) ndone++;
        end
        n_chk++;
        if (ndone !== 0)
            $display("FAIL abort_no_done got=%0d want=0", ndone);
        else n_pass++;
        // Fresh run with stray starts while busy and in DONE.
        exp_q.push_back(model(1));
        @(negedge clk);
        st = 4'd1;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        first = -1;
        ndone = 0;
        for (int c = 1; c <= 90; c++) begin
            @(posedge clk);
            #1;
            if (done === 1'b1) begin
                ndone++;
                if (first < 0) begin
                    first = c;
                    got = dut_res();
                end
            end
            if (c == 9 || c == 37) start = 1'b1;
            if (c == 10 || c == 38) start = 1'b0;
        end
        exp = exp_q.pop_front();
        n_chk++;
        if (first !== 37)
            $display("FAIL restart_latency got=%0d want=37", first);
        else n_pass++;
        n_chk++;
        if (ndone !== 1)
            $display("FAIL ignored_start got=%0d dones want=1", ndone);
        else n_pass++;
        n_chk++;
        if (got !== exp)
            $display("FAIL restart_result got=%h want=%h", got, exp);
        else n_pass++;
    endtask

    initial begin
        clear_mem();
        test_reset();
        test_zero();
        test_b3_only();
        test_w2_path();
        test_saturate();
        test_st_err();
        test_random();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
